obi_master_be: RTL and testbench
================================

Name: obi_master_be

Overview:
- OBI 1.x manager with byte-enable generation; the initiator-side counterpart of obi_slave_be.
- Accepts one load/store at a time from a simple controller port (byte/half/word, right-aligned data).
- Drives OBI A-channel with word-aligned address, lane byte enables and shifted write data.
- Returns lane-extracted, sign/zero-extended read data from the R-channel; one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, OBI address width
DATA_WIDTH, 32, OBI data width; only 32 supported
TIMEOUT_CYCLES, 256, R-channel wait limit (optional feature only)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
ctrl_valid_i  in  1  controller request valid
ctrl_ready_o  out  1  block can accept request
ctrl_addr_i  in  ADDR_WIDTH  byte address
ctrl_we_i  in  1  1=write
ctrl_size_i  in  2  0=byte 1=half 2=word 3=illegal
ctrl_signed_i  in  1  sign-extend read data
ctrl_wdata_i  in  DATA_WIDTH  right-aligned write data
ctrl_rsp_valid_o  out  1  one-cycle response pulse
ctrl_rdata_o  out  DATA_WIDTH  extended read data (0 for writes)
ctrl_err_o  out  1  error, valid with ctrl_rsp_valid_o
obi_req_o, obi_gnt_i  out/in  1  A-channel handshake
obi_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
obi_we_o  out  1  write enable
obi_be_o  out  DATA_WIDTH/8  byte enables
obi_wdata_o  out  DATA_WIDTH  lane-shifted write data
obi_rvalid_i, obi_rready_o  in/out  1  R-channel handshake
obi_rdata_i  in  DATA_WIDTH  read data
obi_err_i  in  1  slave error

Behaviour:
- Clock clk_i; reset reset_i is asynchronous, active-high. All outputs and state registers clear to 0 / IDLE immediately on reset assertion, including mid-transaction; any in-flight transfer is abandoned.
- States: IDLE, ADDR, RESP, ERR (DRAIN only with the optional feature).
- ctrl_ready_o = (state==IDLE). Accept when ctrl_valid_i & ctrl_ready_o.
- Lane offset is off=addr[1:0].
  - be: byte 0001<<off; half 0011<<off; word 1111.
  - wdata: ctrl_wdata_i<<(8*off).
  - Registered at accept and held stable until grant.
- Misalignment rule: half with off odd, word with off!=0, or size 3 -> ERR state. No obi_req_o; next cycle ctrl_rsp_valid_o=1, ctrl_err_o=1, ctrl_rdata_o=0; then IDLE.
- IDLE -> ADDR on accept: obi_req_o rises the cycle after accept.
- ADDR: obi_req_o=1, A-channel outputs held constant until obi_gnt_i. On gnt -> RESP; req drops the following cycle. No back-to-back issue.
- RESP: obi_rready_o=1, otherwise 0. On obi_rvalid_i:
  - next cycle ctrl_rsp_valid_o=1 for exactly one cycle;
  - ctrl_err_o=obi_err_i;
  - ctrl_rdata_o = (obi_rdata_i>>(8*off)) masked to size, sign-extended if ctrl_signed_i, else zero-extended; word passes through; writes return 0;
  - then IDLE.
- rvalid outside RESP/DRAIN is ignored.
- Minimum read latency: accept -> rsp pulse = 4 cycles with gnt and rvalid each in their first possible cycle.

Optional Feature:
OBI_MGR_TIMEOUT_EN:
- Defined: a counter runs in RESP. After TIMEOUT_CYCLES cycles without rvalid:
  - emit rsp pulse with err=1, rdata=0;
  - enter DRAIN: rready=1, ctrl_ready_o=0, until the stale rvalid arrives and is discarded, then IDLE.
- ADDR is never timed out, since OBI forbids retracting req.
- Undefined: no counter, no DRAIN; RESP waits indefinitely.

Decomposition:
- obi_mgr_pkg:
  - state enum;
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants;
  - be_for_size/is_misaligned functions.
- Sub-module obi_lane_align (combinational): be/wdata generation and rdata extract/extend; reused by later managers.

Test Plan:
- Word read 0x10, slave holds DA7A5EAD -> obi_addr_o=0x10, be=1111; ctrl_rdata_o=DA7A5EAD, err=0.
- Signed byte read 0x13 of DA7A5EAD -> be=1000; ctrl_rdata_o=FFFFFFDA. Unsigned -> 000000DA.
- Half write 0x0A, wdata 0x1337 -> obi_addr_o=0x08, be=1100, obi_wdata_o=1337_0000; mem[2] upper half =1337.
- Half at 0x0B, or size 3 -> no obi_req_o ever; rsp pulse next cycle with err=1, rdata=0.
- gnt delayed 3 cycles, then slave err=1 -> req/addr/be/wdata stable all 4 ADDR cycles; rsp err=1. Then reset_i asserted while in RESP -> req/rready/rsp cleared immediately, ready=1 after release.
- With OBI_MGR_TIMEOUT_EN and TIMEOUT_CYCLES=8, rvalid withheld 20 cycles -> err pulse after 8 cycles; ready stays 0 until late rvalid; that rvalid produces no rsp pulse.

Source files
------------

// File: rtl/obi_mgr_pkg.sv
// Shared types and helpers for the OBI manager: FSM states, access size codes,
// and the byte-enable and misalignment rules used by the lane logic.
package obi_mgr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_RESP  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [3:0] be_for_size(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: be_for_size = 4'b0001 << off;
      SIZE_HALF: be_for_size = 4'b0011 << off;
      SIZE_WORD: be_for_size = 4'b1111;
      default:   be_for_size = 4'b0000;
    endcase
  endfunction

  // Size code 3 has no meaning on the bus, so it is reported like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      SIZE_WORD: is_misaligned = (off != 2'd0);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/obi_lane_align.sv
// Combinational lane steering for a 32-bit OBI manager: byte enables and shifted
// write data on the request side, lane extraction and sign/zero extension on reads.
module obi_lane_align
  import obi_mgr_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_off_i,
  input  logic        rd_signed_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  logic [31:0] rd_shift;

  assign be_o     = be_for_size(wr_size_i, wr_off_i);
  assign wdata_o  = wr_data_i << {wr_off_i, 3'b000};
  assign rd_shift = rd_data_i >> {rd_off_i, 3'b000};

  always_comb begin
    rd_data_o = rd_shift;
    case (rd_size_i)
      SIZE_BYTE: rd_data_o = {{24{rd_signed_i & rd_shift[7]}}, rd_shift[7:0]};
      SIZE_HALF: rd_data_o = {{16{rd_signed_i & rd_shift[15]}}, rd_shift[15:0]};
      default:   rd_data_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/obi_master_be.sv
// OBI 1.x manager with byte-enable generation, one outstanding transaction.
// Optional R-channel timeout with drain of the late response: define OBI_MGR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a controller request
// ADDR  | obi_req_o high, A-channel held until grant
// RESP  | waiting for rvalid (rready high)
// ERR   | misaligned/illegal request, error pulse this cycle
// DRAIN | timed out, swallowing the late rvalid
module obi_master_be
  import obi_mgr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    ctrl_valid_i,
  output logic                    ctrl_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ctrl_addr_i,
  input  logic                    ctrl_we_i,
  input  logic [1:0]              ctrl_size_i,
  input  logic                    ctrl_signed_i,
  input  logic [DATA_WIDTH-1:0]   ctrl_wdata_i,
  output logic                    ctrl_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ctrl_rdata_o,
  output logic                    ctrl_err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:2] addr_q;
  logic                  we_q;
  logic                  signed_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [31:0]           rsp_rdata_q;

  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] rdata_ext;
  logic        accept;
  logic        timeout_hit;
  logic        rsp_fire;

  assign accept   = ctrl_valid_i & ctrl_ready_o;
  assign rsp_fire = (state_q == ST_RESP) & (obi_rvalid_i | timeout_hit);

  obi_lane_align u_align (
    .wr_size_i   (ctrl_size_i),
    .wr_off_i    (ctrl_addr_i[1:0]),
    .wr_data_i   (ctrl_wdata_i),
    .be_o        (be_w),
    .wdata_o     (wdata_w),
    .rd_size_i   (size_q),
    .rd_off_i    (off_q),
    .rd_signed_i (signed_q),
    .rd_data_i   (obi_rdata_i),
    .rd_data_o   (rdata_ext)
  );

`ifdef OBI_MGR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // Loaded on grant so the first RESP cycle already counts toward the limit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ADDR && obi_gnt_i) begin
      tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == ST_RESP && tmo_cnt_q != '0) begin
      tmo_cnt_q <= tmo_cnt_q - 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_RESP) & ~obi_rvalid_i & (tmo_cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_misaligned(ctrl_size_i, ctrl_addr_i[1:0]) ? ST_ERR : ST_ADDR;
      ST_ADDR: if (obi_gnt_i) state_d = ST_RESP;
      ST_RESP: begin
        if (obi_rvalid_i) state_d = ST_IDLE;
`ifdef OBI_MGR_TIMEOUT_EN
        else if (timeout_hit) state_d = ST_DRAIN;
`endif
      end
      ST_ERR: state_d = ST_IDLE;
`ifdef OBI_MGR_TIMEOUT_EN
      ST_DRAIN: if (obi_rvalid_i) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_ready_o     = 1'b0;
    obi_req_o        = 1'b0;
    obi_rready_o     = 1'b0;
    ctrl_rsp_valid_o = rsp_valid_q;
    ctrl_err_o       = rsp_err_q;
    ctrl_rdata_o     = rsp_rdata_q;
    case (state_q)
      ST_IDLE:  ctrl_ready_o = 1'b1;
      ST_ADDR:  obi_req_o    = 1'b1;
      ST_RESP:  obi_rready_o = 1'b1;
      ST_DRAIN: obi_rready_o = 1'b1;
      ST_ERR: begin
        ctrl_rsp_valid_o = 1'b1;
        ctrl_err_o       = 1'b1;
        ctrl_rdata_o     = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        addr_q   <= ctrl_addr_i[ADDR_WIDTH-1:2];
        we_q     <= ctrl_we_i;
        signed_q <= ctrl_signed_i;
        size_q   <= ctrl_size_i;
        off_q    <= ctrl_addr_i[1:0];
        be_q     <= be_w;
        wdata_q  <= wdata_w;
      end
      rsp_valid_q <= rsp_fire;
      rsp_err_q   <= rsp_fire & (obi_rvalid_i ? obi_err_i : 1'b1);
      rsp_rdata_q <= (rsp_fire & obi_rvalid_i & ~we_q) ? rdata_ext : 32'd0;
    end
  end

  assign obi_addr_o  = {addr_q, 2'b00};
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_obi_master_be.sv
// Self-checking bench for obi_master_be: directed plan cases plus randomized
// transactions checked against a byte-level memory reference model.
module tb_obi_master_be;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          ctrl_valid_i;
  logic          ctrl_ready_o;
  logic [AW-1:0] ctrl_addr_i;
  logic          ctrl_we_i;
  logic [1:0]    ctrl_size_i;
  logic          ctrl_signed_i;
  logic [DW-1:0] ctrl_wdata_i;
  logic          ctrl_rsp_valid_o;
  logic [DW-1:0] ctrl_rdata_o;
  logic          ctrl_err_o;
  logic          obi_req_o;
  logic          obi_gnt_i;
  logic [AW-1:0] obi_addr_o;
  logic          obi_we_o;
  logic [3:0]    obi_be_o;
  logic [DW-1:0] obi_wdata_o;
  logic          obi_rvalid_i;
  logic          obi_rready_o;
  logic [DW-1:0] obi_rdata_i;
  logic          obi_err_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem   [16];

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always #5 clk_i = ~clk_i;

  obi_master_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ctrl_valid_i(ctrl_valid_i), .ctrl_ready_o(ctrl_ready_o), .ctrl_addr_i(ctrl_addr_i),
    .ctrl_we_i(ctrl_we_i), .ctrl_size_i(ctrl_size_i), .ctrl_signed_i(ctrl_signed_i),
    .ctrl_wdata_i(ctrl_wdata_i), .ctrl_rsp_valid_o(ctrl_rsp_valid_o), .ctrl_rdata_o(ctrl_rdata_o),
    .ctrl_err_o(ctrl_err_o), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i),
    .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
  );

  // ---------------- reference model ----------------
  function automatic bit model_misaligned(int size, int off);
    if (size == 3) return 1'b1;
    return (off % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(int size, int off);
    logic [3:0] b = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + (1 << size)) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] w, int size, int off, bit sgn);
    longint v = 0;
    int n = 1 << size;
    for (int k = 0; k < n; k++) v = v + (longint'(w[8*(off+k) +: 8]) << (8*k));
    if (sgn && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_write(logic [31:0] w, int size, int off, logic [31:0] wd);
    logic [31:0] r = w;
    for (int k = 0; k < (1 << size); k++) r[8*(off+k) +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Drives one controller transaction and plays the OBI slave with the given delays.
  task automatic run_txn(input logic [31:0] addr, input bit we, input int size, input bit sgn,
                         input logic [31:0] wdata, input int gd, input int rd, input bit serr,
                         output logic [31:0] got_rdata, output logic got_err, output int lat);
    int          off = int'(addr[1:0]);
    int          wi  = int'(addr[5:2]);
    bit          mis = model_misaligned(size, off);
    logic [3:0]  exp_be = model_be(size, off);
    logic [31:0] exp_wd = wdata << (8*off);
    logic [31:0] exp_rd;
    got_rdata = 'x; got_err = 1'bx;
    @(negedge clk_i);
    checks++;
    if (ctrl_ready_o !== 1'b1) begin errors++; $display("FAIL ready_idle got %b want 1", ctrl_ready_o); end
    ctrl_valid_i = 1'b1; ctrl_addr_i = addr; ctrl_we_i = we; ctrl_size_i = 2'(size);
    ctrl_signed_i = sgn; ctrl_wdata_i = wdata;
    @(posedge clk_i); #1;
    ctrl_valid_i = 1'b0; ctrl_addr_i = $urandom; ctrl_wdata_i = $urandom; ctrl_size_i = 2'($urandom);
    lat = 1;
    if (mis) begin
      @(negedge clk_i); lat++;
      got_rdata = ctrl_rdata_o; got_err = ctrl_err_o;
      checks++;
      if ({obi_req_o, ctrl_rsp_valid_o, ctrl_err_o, ctrl_rdata_o} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
        errors++;
        $display("FAIL misalign_rsp got req=%b rsp=%b err=%b rdata=%h want 0 1 1 0",
                 obi_req_o, ctrl_rsp_valid_o, ctrl_err_o, ctrl_rdata_o);
      end
      @(negedge clk_i);
      checks++;
      if ({obi_req_o, ctrl_rsp_valid_o, ctrl_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL misalign_after got req=%b rsp=%b ready=%b want 0 0 1", obi_req_o, ctrl_rsp_valid_o, ctrl_ready_o);
      end
      return;
    end
    for (int c = 0; c <= gd; c++) begin
      @(negedge clk_i); lat++;
      checks++;
      if ({obi_req_o, obi_we_o, obi_addr_o, obi_be_o, obi_wdata_o, ctrl_rsp_valid_o} !==
          {1'b1, we, addr[31:2], 2'b00, exp_be, exp_wd, 1'b0}) begin
        errors++;
        $display("FAIL a_chan cyc%0d got req=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h", c, obi_req_o,
                 obi_we_o, obi_addr_o, obi_be_o, obi_wdata_o, we, {addr[31:2], 2'b00}, exp_be, exp_wd);
      end
      obi_gnt_i = (c == gd);
    end
    cap_addr = obi_addr_o; cap_be = obi_be_o; cap_wdata = obi_wdata_o;
    if (obi_we_o && !serr)
      for (int b = 0; b < 4; b++)
        if (obi_be_o[b]) slave_mem[obi_addr_o[5:2]][8*b +: 8] = obi_wdata_o[8*b +: 8];
    @(posedge clk_i); #1;
    obi_gnt_i = 1'b0;
    for (int c = 0; c <= rd; c++) begin
      @(negedge clk_i); lat++;
      checks++;
      if ({obi_req_o, obi_rready_o, ctrl_rsp_valid_o} !== 3'b010) begin
        errors++;
        $display("FAIL r_wait cyc%0d got req=%b rready=%b rsp=%b want 0 1 0", c, obi_req_o, obi_rready_o, ctrl_rsp_valid_o);
      end
      if (c == rd) begin
        obi_rvalid_i = 1'b1; obi_rdata_i = slave_mem[wi]; obi_err_i = serr;
      end
    end
    @(posedge clk_i); #1;
    obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = $urandom;
    @(negedge clk_i); lat++;
    exp_rd = we ? 32'd0 : model_read(ref_mem[wi], size, off, sgn);
    got_rdata = ctrl_rdata_o; got_err = ctrl_err_o;
    checks++;
    if ({ctrl_rsp_valid_o, ctrl_err_o, ctrl_rdata_o, obi_rready_o} !== {1'b1, serr, exp_rd, 1'b0}) begin
      errors++;
      $display("FAIL rsp addr=%h got v=%b err=%b rdata=%h rready=%b want 1 %b %h 0", addr,
               ctrl_rsp_valid_o, ctrl_err_o, ctrl_rdata_o, obi_rready_o, serr, exp_rd);
    end
    if (we && !serr) ref_mem[wi] = model_write(ref_mem[wi], size, off, wdata);
    @(negedge clk_i);
    checks++;
    if (ctrl_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle got %b want 0", ctrl_rsp_valid_o); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({ctrl_ready_o, obi_req_o, obi_rready_o, ctrl_rsp_valid_o, obi_be_o, obi_addr_o, obi_wdata_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got ready=%b req=%b rready=%b rsp=%b be=%b addr=%h wd=%h want 1 0 0 0 0 0 0",
               ctrl_ready_o, obi_req_o, obi_rready_o, ctrl_rsp_valid_o, obi_be_o, obi_addr_o, obi_wdata_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ctrl_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release got ready=%b want 1", ctrl_ready_o); end
  endtask

  task automatic test_directed();
    logic [31:0] r; logic e; int lat;
    slave_mem[4] = 32'hDA7A5EAD; ref_mem[4] = 32'hDA7A5EAD;
    run_txn(32'h10, 1'b0, 2, 1'b0, 32'h0, 0, 0, 1'b0, r, e, lat);
    checks++;
    if ({cap_addr, cap_be, r, e} !== {32'h10, 4'b1111, 32'hDA7A5EAD, 1'b0}) begin
      errors++; $display("FAIL word_read got addr=%h be=%b rdata=%h err=%b want 10 1111 DA7A5EAD 0", cap_addr, cap_be, r, e);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL min_latency got %0d want 4", lat); end
    run_txn(32'h13, 1'b0, 0, 1'b1, 32'h0, 0, 0, 1'b0, r, e, lat);
    checks++;
    if ({cap_be, r} !== {4'b1000, 32'hFFFFFFDA}) begin
      errors++; $display("FAIL byte_signed got be=%b rdata=%h want 1000 FFFFFFDA", cap_be, r);
    end
    run_txn(32'h13, 1'b0, 0, 1'b0, 32'h0, 1, 2, 1'b0, r, e, lat);
    checks++;
    if (r !== 32'h000000DA) begin errors++; $display("FAIL byte_unsigned got %h want 000000DA", r); end
    slave_mem[2] = 32'h0000BEEF; ref_mem[2] = 32'h0000BEEF;
    run_txn(32'h0A, 1'b1, 1, 1'b0, 32'h1337, 0, 0, 1'b0, r, e, lat);
    checks++;
    if ({cap_addr, cap_be, cap_wdata, slave_mem[2]} !== {32'h08, 4'b1100, 32'h13370000, 32'h1337BEEF}) begin
      errors++; $display("FAIL half_write got addr=%h be=%b wd=%h mem=%h want 08 1100 13370000 1337BEEF",
                         cap_addr, cap_be, cap_wdata, slave_mem[2]);
    end
    run_txn(32'h0A, 1'b0, 1, 1'b1, 32'h0, 0, 0, 1'b0, r, e, lat);
    checks++;
    if (r !== 32'h00001337) begin errors++; $display("FAIL half_readback got %h want 00001337", r); end
  endtask

  task automatic test_misaligned();
    logic [31:0] r; logic e; int lat;
    run_txn(32'h0B, 1'b0, 1, 1'b0, 32'h0, 0, 0, 1'b0, r, e, lat);
    checks++;
    if ({r, e, lat} !== {32'd0, 1'b1, 32'd2}) begin
      errors++; $display("FAIL half_odd got rdata=%h err=%b lat=%0d want 0 1 2", r, e, lat);
    end
    run_txn(32'h04, 1'b1, 3, 1'b0, 32'hFFFF, 0, 0, 1'b0, r, e, lat);
    checks++;
    if ({r, e} !== {32'd0, 1'b1}) begin errors++; $display("FAIL size3 got rdata=%h err=%b want 0 1", r, e); end
    run_txn(32'h12, 1'b0, 2, 1'b0, 32'h0, 0, 0, 1'b0, r, e, lat);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL word_off2 got err=%b want 1", e); end
  endtask

  task automatic test_gnt_delay_and_reset();
    logic [31:0] r; logic e; int lat;
    run_txn(32'h22, 1'b1, 1, 1'b0, 32'hA5C3, 3, 1, 1'b1, r, e, lat);
    checks++;
    if ({e, r, lat} !== {1'b1, 32'd0, 32'd8}) begin
      errors++; $display("FAIL gnt_delay_err got err=%b rdata=%h lat=%0d want 1 0 8", e, r, lat);
    end
    @(negedge clk_i);
    ctrl_valid_i = 1'b1; ctrl_addr_i = 32'h10; ctrl_we_i = 1'b0; ctrl_size_i = 2'd2; ctrl_signed_i = 1'b0;
    @(posedge clk_i); #1 ctrl_valid_i = 1'b0;
    @(negedge clk_i); obi_gnt_i = 1'b1;
    @(posedge clk_i); #1 obi_gnt_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    checks++;
    if ({obi_req_o, obi_rready_o, ctrl_rsp_valid_o} !== 3'b000) begin
      errors++; $display("FAIL reset_in_resp got req=%b rready=%b rsp=%b want 0 0 0", obi_req_o, obi_rready_o, ctrl_rsp_valid_o);
    end
    @(negedge clk_i); reset_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({ctrl_ready_o, obi_rready_o, ctrl_rsp_valid_o} !== 3'b100) begin
      errors++; $display("FAIL reset_release_resp got ready=%b rready=%b rsp=%b want 1 0 0", ctrl_ready_o, obi_rready_o, ctrl_rsp_valid_o);
    end
  endtask

  task automatic test_rvalid_ignored();
    @(negedge clk_i);
    obi_rvalid_i = 1'b1; obi_err_i = 1'b1; obi_rdata_i = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk_i);
      checks++;
      if ({ctrl_rsp_valid_o, ctrl_ready_o, obi_rready_o} !== 3'b010) begin
        errors++; $display("FAIL rvalid_idle got rsp=%b ready=%b rready=%b want 0 1 0", ctrl_rsp_valid_o, ctrl_ready_o, obi_rready_o);
      end
    end
    obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] r, a; logic e; int lat, sz, gd, rd; bit we;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom; ref_mem[i] = slave_mem[i];
    end
    for (int n = 0; n < 80; n++) begin
      a  = $urandom;
      sz = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1));
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      run_txn(a, we, sz, 1'($urandom_range(0, 1)), $urandom, gd, rd, ($urandom_range(0, 7) == 0), r, e, lat);
      checks++;
      if (model_misaligned(sz, int'(a[1:0]))) begin
        if (lat !== 2) begin errors++; $display("FAIL rand_lat_err n=%0d got %0d want 2", n, lat); end
      end else if (lat !== 4 + gd + rd) begin
        errors++; $display("FAIL rand_lat n=%0d got %0d want %0d", n, lat, 4 + gd + rd);
      end
    end
  endtask

`ifdef OBI_MGR_TIMEOUT_EN
  task automatic test_timeout();
    int waited = 0;
    bit seen = 1'b0;
    @(negedge clk_i);
    ctrl_valid_i = 1'b1; ctrl_addr_i = 32'h10; ctrl_we_i = 1'b0; ctrl_size_i = 2'd2; ctrl_signed_i = 1'b0;
    @(posedge clk_i); #1 ctrl_valid_i = 1'b0;
    @(negedge clk_i); obi_gnt_i = 1'b1;
    @(posedge clk_i); #1 obi_gnt_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (!seen) begin
        if (ctrl_rsp_valid_o) begin
          seen = 1'b1;
          checks++;
          if ({waited, ctrl_err_o, ctrl_rdata_o} !== {32'd8, 1'b1, 32'd0}) begin
            errors++; $display("FAIL timeout_pulse got wait=%0d err=%b rdata=%h want 8 1 0", waited, ctrl_err_o, ctrl_rdata_o);
          end
        end else if (obi_rready_o) waited++;
      end else begin
        checks++;
        if ({ctrl_ready_o, ctrl_rsp_valid_o, obi_rready_o} !== 3'b001) begin
          errors++; $display("FAIL drain_hold c=%0d got ready=%b rsp=%b rready=%b want 0 0 1", c, ctrl_ready_o, ctrl_rsp_valid_o, obi_rready_o);
        end
      end
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL timeout_seen got 0 want 1"); end
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h12345678;
    @(posedge clk_i); #1 obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({ctrl_rsp_valid_o, ctrl_ready_o, obi_rready_o} !== 3'b010) begin
      errors++; $display("FAIL late_rvalid got rsp=%b ready=%b rready=%b want 0 1 0", ctrl_rsp_valid_o, ctrl_ready_o, obi_rready_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; ctrl_valid_i = 1'b0; ctrl_addr_i = '0; ctrl_we_i = 1'b0; ctrl_size_i = 2'd0;
    ctrl_signed_i = 1'b0; ctrl_wdata_i = '0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
    obi_rdata_i = '0; obi_err_i = 1'b0;
    for (int i = 0; i < 16; i++) begin slave_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    test_reset();
    test_directed();
    test_misaligned();
    test_gnt_delay_and_reset();
    test_rvalid_ignored();
`ifdef OBI_MGR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
